encoder_8_to_3_seq: RTL

Sequential 8-to-3 binary encoder, the inverse of the decoder_3_to_8 block. It captures an 8-bit request vector (the decoder's one-hot "out" domain) and emits the 3-bit binary index of every set bit, lowest index first, one index per accepted transfer. A valid/ready handshake sits on both sides. It serves as the re-encoder that turns decoded select lines back into binary addresses.

---
 rtl/encoder_8_to_3_seq_pkg.sv | 12 +
 rtl/encoder_8_to_3_seq_if.sv | 30 +++
 rtl/encoder_8_to_3_seq_lse.sv | 24 ++
 rtl/encoder_8_to_3_seq.sv | 109 ++++++++++
 4 files changed

// File: rtl/encoder_8_to_3_seq_pkg.sv
// Constants and state type shared by the 3-to-8 decoder and the 8-to-3 re-encoder.
package decoder_pkg;

  localparam int DEC_WIDTH = 8;
  localparam int DEC_AW    = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } enc_state_t;

endpackage

// File: rtl/encoder_8_to_3_seq_if.sv
// Request-in / index-out handshake bundle of the sequential encoder.
interface encoder_8_to_3_seq_if
  import decoder_pkg::*;
#(
  parameter int WIDTH = DEC_WIDTH,
  parameter int AW    = DEC_AW
) ();

  logic             en;
  logic [WIDTH-1:0] in_vec;
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    a;
  logic             a_valid;
  logic             a_ready;
  logic             a_last;
  logic             none;

  // master drives requests and accepts indices; slave is the encoder
  modport master (
    output en, in_vec, in_valid, a_ready,
    input  in_ready, a, a_valid, a_last, none
  );

  modport slave (
    input  en, in_vec, in_valid, a_ready,
    output in_ready, a, a_valid, a_last, none
  );

endinterface

// File: rtl/encoder_8_to_3_seq_lse.sv
// Combinational priority encoder: index of the lowest set bit plus nonzero/one-hot flags.
module lowest_set_encoder
  import decoder_pkg::*;
#(
  parameter int WIDTH = DEC_WIDTH,
  parameter int AW    = DEC_AW
) (
  input  logic [WIDTH-1:0] vec,
  output logic [AW-1:0]    idx,
  output logic             nonzero,
  output logic             single
);

  // descending scan so the lowest set bit is the last one written
  always_comb begin
    idx = {AW{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      idx = vec[i] ? AW'(i) : idx;
    end
    nonzero = |vec;
    single  = nonzero && ((vec & (vec - WIDTH'(1))) == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/encoder_8_to_3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and emits the index of
// every set bit, lowest first, one per valid/ready transfer.
module encoder_8_to_3_seq
  import decoder_pkg::*;
#(
  parameter int WIDTH = DEC_WIDTH,
  parameter int AW    = DEC_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  encoder_8_to_3_seq_if.slave   bus
);

  enc_state_t       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             none_q, none_d;

  logic [AW-1:0]    enc_idx;
  logic             enc_nonzero;
  logic             enc_single;
  logic             in_ready_s;
  logic             a_valid_s;
  logic             xfer_s;

  lowest_set_encoder #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_lse (
    .vec     (pending_q),
    .idx     (enc_idx),
    .nonzero (enc_nonzero),
    .single  (enc_single)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= {WIDTH{1'b0}};
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  // next-state: capture in IDLE, retire one bit per transfer in SCAN
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && bus.in_valid) begin
          if (bus.in_vec != {WIDTH{1'b0}}) begin
            pending_d = bus.in_vec;
            state_d   = SCAN;
          end else begin
            none_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (xfer_s) begin
          pending_d = pending_q & ~(WIDTH'(1) << enc_idx);
          state_d   = enc_single ? IDLE : SCAN;
        end else begin
          state_d = SCAN;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = {WIDTH{1'b0}};
      end
    endcase
  end

  // outputs; in_ready is gated by rst so it reads 0 while reset is held
  always_comb begin
    in_ready_s = 1'b0;
    a_valid_s  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_s = bus.en && !rst;
        a_valid_s  = 1'b0;
      end
      SCAN: begin
        in_ready_s = 1'b0;
        a_valid_s  = bus.en && enc_nonzero;
      end
      default: begin
        in_ready_s = 1'b0;
        a_valid_s  = 1'b0;
      end
    endcase
    xfer_s = a_valid_s && bus.a_ready;
  end

  assign bus.in_ready = in_ready_s;
  assign bus.a_valid  = a_valid_s;
  assign bus.a        = a_valid_s ? enc_idx : {AW{1'b0}};
  assign bus.a_last   = a_valid_s && enc_single;
  assign bus.none     = none_q;

endmodule
